mat_mac_seq: RTL and testbench

Sequencer that computes one N×N matrix product C = A·B on a single shared MAC unit (4-bit operands, 10-bit accumulator, `clear`/`load` controls). It walks the operand memories for A and B, and issues one `clear` plus N `load` cycles per output element. Each finished element of C is presented on a valid/ready output port. It sits between the operand register files and the result sink and is the sole master of the MAC's control inputs.

---
 rtl/mat_mac_seq_if.sv | 19 +
 rtl/mat_mac_seq.sv | 146 ++++++++++++++
 tb/tb_mat_mac_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_mac_seq_if.sv
// rtl/mat_mac_seq_if.sv - result element stream between the sequencer and the result sink
//
// Ports (interface signals):
//   c_data  [9:0]  element value (accumulator sum)
//   c_row   [1:0]  row index i of the element
//   c_col   [1:0]  column index j of the element
//   c_valid        element available
//   c_ready        sink accepts the element
// Modports: master = sequencer side, slave = sink side.
interface mat_mac_seq_if;
    logic [9:0] c_data;
    logic [1:0] c_row;
    logic [1:0] c_col;
    logic       c_valid;
    logic       c_ready;

    modport master (output c_data, c_row, c_col, c_valid, input c_ready);
    modport slave  (input c_data, c_row, c_col, c_valid, output c_ready);
endinterface

// File: rtl/mat_mac_seq.sv
// rtl/mat_mac_seq.sv - sequencer driving one shared MAC to compute C = A*B for N x N matrices
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request a product (sampled only in IDLE)
//   busy, done          status; done pulses once after the last element is accepted
//   a_addr, b_addr      row-major operand addresses i*N+k and k*N+j
//   a_data, b_data      combinational operand read data
//   mac_w, mac_x        MAC operands (pass-through of a_data / b_data)
//   mac_clear, mac_load MAC controls, never both high
//   mac_o               MAC accumulator output
//   c_if                result element stream (master side)
module mat_mac_seq #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           a_addr,
    output logic [3:0]           b_addr,
    input  logic [3:0]           a_data,
    input  logic [3:0]           b_data,
    output logic [3:0]           mac_w,
    output logic [3:0]           mac_x,
    output logic                 mac_clear,
    output logic                 mac_load,
    input  logic [9:0]           mac_o,
    mat_mac_seq_if.master        c_if
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACC   = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] LAST = 2'(N - 1);

    state_t     state_q, state_d;
    logic [1:0] i_q, i_d;
    logic [1:0] j_q, j_d;
    logic [1:0] k_q, k_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       clear_q, clear_d;
    logic       load_q, load_d;
    logic       valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    i_d     = 2'd0;
                    j_d     = 2'd0;
                    k_d     = 2'd0;
                end
            end
            CLEAR: state_d = ACC;
            ACC: begin
                if (k_q == LAST) begin
                    k_d     = 2'd0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            OUT: begin
                if (c_if.c_ready) begin
                    if (i_q == LAST && j_q == LAST) begin
                        // Park counters at zero so IDLE addresses read 0.
                        state_d = DONE;
                        i_d     = 2'd0;
                        j_d     = 2'd0;
                    end else begin
                        state_d = CLEAR;
                        if (j_q == LAST) begin
                            j_d = 2'd0;
                            i_d = i_q + 2'd1;
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the next state.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        clear_d = (state_d == CLEAR);
        load_d  = (state_d == ACC);
        valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            k_q     <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clear_q <= clear_d;
            load_q  <= load_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_clear = clear_q;
    assign mac_load  = load_q;

    assign a_addr = 4'(i_q) * 4'(N) + 4'(k_q);
    assign b_addr = 4'(k_q) * 4'(N) + 4'(j_q);
    assign mac_w  = a_data;
    assign mac_x  = b_data;

    // The MAC has no reset, so mac_o is gated to keep c_data at 0 outside OUT.
    assign c_if.c_valid = valid_q;
    assign c_if.c_data  = valid_q ? mac_o : 10'd0;
    assign c_if.c_row   = i_q;
    assign c_if.c_col   = j_q;

endmodule

// File: tb/tb_mat_mac_seq.sv
// tb/tb_mat_mac_seq.sv - self-checking bench for mat_mac_seq with N=2, N=4 and N=1 instances
module tb_mat_mac_seq;

    typedef struct packed {
        int              g;          // 0: N=2, 1: N=4, 2: N=1
        logic [15:0][3:0] a;
        logic [15:0][3:0] b;
        int              stall_idx;
        int              stall_len;
        bit              poke;       // re-assert start in cycles 3 and 10
        logic [15:0][9:0] exp;
        int              exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_r [3];
    logic       ready_r [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       clr_w   [3];
    logic       ld_w    [3];
    logic       valid_w [3];
    logic [3:0] aaddr_w [3];
    logic [3:0] baddr_w [3];
    logic [3:0] adata_w [3];
    logic [3:0] bdata_w [3];
    logic [3:0] w_w     [3];
    logic [3:0] x_w     [3];
    logic [9:0] maco_w  [3];
    logic [9:0] cdata_w [3];
    logic [1:0] row_w   [3];
    logic [1:0] col_w   [3];
    logic [3:0] mem_a   [3][16];
    logic [3:0] mem_b   [3][16];

    int n_cmp = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NN = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        mat_mac_seq_if cif ();
        logic [9:0] acc;

        assign cif.c_ready = ready_r[g];
        assign valid_w[g]  = cif.c_valid;
        assign cdata_w[g]  = cif.c_data;
        assign row_w[g]    = cif.c_row;
        assign col_w[g]    = cif.c_col;
        assign adata_w[g]  = mem_a[g][aaddr_w[g]];
        assign bdata_w[g]  = mem_b[g][baddr_w[g]];
        assign maco_w[g]   = acc;

        // Reference MAC: no reset, clear has priority.
        always @(posedge clk) begin
            if (clr_w[g]) acc <= 10'd0;
            else if (ld_w[g]) acc <= acc + 10'(w_w[g]) * 10'(x_w[g]);
        end

        mat_mac_seq #(.N(NN)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_r[g]),
            .busy(busy_w[g]), .done(done_w[g]),
            .a_addr(aaddr_w[g]), .b_addr(baddr_w[g]),
            .a_data(adata_w[g]), .b_data(bdata_w[g]),
            .mac_w(w_w[g]), .mac_x(x_w[g]),
            .mac_clear(clr_w[g]), .mac_load(ld_w[g]),
            .mac_o(maco_w[g]), .c_if(cif)
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input int g, input string tag);
        check({tag, " busy"}, int'(busy_w[g]), 0);
        check({tag, " done"}, int'(done_w[g]), 0);
        check({tag, " c_valid"}, int'(valid_w[g]), 0);
        check({tag, " mac_clear"}, int'(clr_w[g]), 0);
        check({tag, " mac_load"}, int'(ld_w[g]), 0);
        check({tag, " a_addr"}, int'(aaddr_w[g]), 0);
        check({tag, " b_addr"}, int'(baddr_w[g]), 0);
        check({tag, " c_data"}, int'(cdata_w[g]), 0);
        check({tag, " c_row"}, int'(row_w[g]), 0);
        check({tag, " c_col"}, int'(col_w[g]), 0);
    endtask

    task automatic load_mem(input vec_t v);
        for (int idx = 0; idx < 16; idx++) begin
            mem_a[v.g][idx] = v.a[idx];
            mem_b[v.g][idx] = v.b[idx];
        end
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int  g, n, cyc, e, stall_cnt, held;
        bit  fin, first_seen;
        g = v.g;
        n = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        load_mem(v);
        @(negedge clk);
        check({tag, " idle busy"}, int'(busy_w[g]), 0);
        start_r[g] = 1'b1;
        ready_r[g] = 1'b1;
        cyc = 0; e = 0; stall_cnt = 0; held = 0; fin = 0; first_seen = 0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_r[g] = v.poke && (cyc == 3 || cyc == 10);
            check($sformatf("%s busy c%0d", tag, cyc), int'(busy_w[g]), 1);
            check($sformatf("%s clear&load c%0d", tag, cyc), int'(clr_w[g] & ld_w[g]), 0);
            if (valid_w[g]) begin
                if (!first_seen) begin
                    check({tag, " first c_valid cycle"}, cyc, n + 2);
                    first_seen = 1;
                end
                check($sformatf("%s e%0d c_data", tag, e), int'(cdata_w[g]), int'(v.exp[e]));
                check($sformatf("%s e%0d c_row", tag, e), int'(row_w[g]), e / n);
                check($sformatf("%s e%0d c_col", tag, e), int'(col_w[g]), e % n);
                if (e == v.stall_idx) held++;
                if (e == v.stall_idx && stall_cnt < v.stall_len) begin
                    ready_r[g] = 1'b0;
                    stall_cnt++;
                end else begin
                    ready_r[g] = 1'b1;
                    e++;
                end
            end else begin
                ready_r[g] = 1'b1;
            end
            if (done_w[g]) begin
                check({tag, " done cycle"}, cyc, v.exp_done);
                check({tag, " element count"}, e, n * n);
                fin = 1;
            end
        end
        if (!fin) check({tag, " done timeout"}, 0, 1);
        start_r[g] = 1'b0;
        ready_r[g] = 1'b1;
        if (v.stall_len > 0) check({tag, " OUT cycles of stalled element"}, held, v.stall_len + 1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check($sformatf("%s post busy %0d", tag, t), int'(busy_w[g]), 0);
            check($sformatf("%s post done %0d", tag, t), int'(done_w[g]), 0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vec_t r;
        int   cyc;
        bit   fin;

        for (int g = 0; g < 3; g++) begin
            start_r[g] = 1'b0;
            ready_r[g] = 1'b1;
            for (int idx = 0; idx < 16; idx++) begin
                mem_a[g][idx] = 4'd0;
                mem_b[g][idx] = 4'd0;
            end
        end

        vecs[0] = '{g: 0, a: {48'd0, 4'd4, 4'd3, 4'd2, 4'd1}, b: {48'd0, 4'd1, 4'd0, 4'd0, 4'd1},
                    stall_idx: -1, stall_len: 0, poke: 0,
                    exp: {120'd0, 10'd4, 10'd3, 10'd2, 10'd1}, exp_done: 17};
        vecs[1] = '{g: 1, a: {16{4'hF}}, b: {16{4'hF}},
                    stall_idx: -1, stall_len: 0, poke: 0,
                    exp: {16{10'd900}}, exp_done: 97};
        vecs[2] = '{g: 0, a: {48'd0, 4'd4, 4'd3, 4'd2, 4'd1}, b: {48'd0, 4'd8, 4'd7, 4'd6, 4'd5},
                    stall_idx: 1, stall_len: 3, poke: 0,
                    exp: {120'd0, 10'd50, 10'd43, 10'd22, 10'd19}, exp_done: 20};
        vecs[3] = '{g: 0, a: {48'd0, 4'd4, 4'd3, 4'd2, 4'd1}, b: {48'd0, 4'd8, 4'd7, 4'd6, 4'd5},
                    stall_idx: -1, stall_len: 0, poke: 1,
                    exp: {120'd0, 10'd50, 10'd43, 10'd22, 10'd19}, exp_done: 17};
        vecs[4] = '{g: 2, a: {60'd0, 4'd15}, b: {60'd0, 4'd15},
                    stall_idx: -1, stall_len: 0, poke: 0,
                    exp: {150'd0, 10'd225}, exp_done: 4};
        vecs[5] = '{g: 0, a: {48'd0, 4'd1, 4'd0, 4'd0, 4'd1}, b: {48'd0, 4'd1, 4'd0, 4'd0, 4'd1},
                    stall_idx: -1, stall_len: 0, poke: 0,
                    exp: {120'd0, 10'd1, 10'd0, 10'd0, 10'd1}, exp_done: 17};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) check_zero(g, $sformatf("reset g%0d", g));
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) run_case(vecs[v], $sformatf("vec%0d", v));

        // Reset during ACC of element (1,0), then an identity run must flush the MAC.
        r = vecs[2];
        load_mem(r);
        @(negedge clk);
        start_r[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
        end
        check("mid-run load", int'(ld_w[0]), 1);
        check("mid-run a_addr", int'(aaddr_w[0]), 2);
        check("mid-run b_addr", int'(baddr_w[0]), 0);
        check("mid-run c_row", int'(row_w[0]), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero(0, "abort");
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check($sformatf("abort valid %0d", t), int'(valid_w[0]), 0);
            check($sformatf("abort done %0d", t), int'(done_w[0]), 0);
        end
        run_case(vecs[5], "flush");

        // N=1 cycle-exact sequence, start in DONE ignored, start in next IDLE accepted.
        load_mem(vecs[4]);
        @(negedge clk);
        start_r[2] = 1'b1;
        @(negedge clk);
        start_r[2] = 1'b0;
        check("n1 c1 clear", int'(clr_w[2]), 1);
        check("n1 c1 load", int'(ld_w[2]), 0);
        @(negedge clk);
        check("n1 c2 clear", int'(clr_w[2]), 0);
        check("n1 c2 load", int'(ld_w[2]), 1);
        @(negedge clk);
        check("n1 c3 valid", int'(valid_w[2]), 1);
        check("n1 c3 c_data", int'(cdata_w[2]), 225);
        @(negedge clk);
        check("n1 c4 done", int'(done_w[2]), 1);
        check("n1 c4 valid", int'(valid_w[2]), 0);
        start_r[2] = 1'b1;
        @(negedge clk);
        check("n1 c5 busy", int'(busy_w[2]), 0);
        @(negedge clk);
        start_r[2] = 1'b0;
        check("n1 restart busy", int'(busy_w[2]), 1);
        check("n1 restart clear", int'(clr_w[2]), 1);
        cyc = 0;
        fin = 0;
        while (!fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done_w[2]) fin = 1;
        end
        check("n1 restart done timeout", int'(fin), 1);
        check("n1 restart done cycle", cyc + 1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
